// File: rtl/ppm_sram_loader_pkg.sv
// Shared definitions for the PPM-to-SRAM loader: FSM states, protocol constants
// and a width helper for parameter-sized counters.
package ppm_sram_loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HEADER,
      S_PAYLOAD,
      S_FLUSH,
      S_DONE
   } loader_state_t;

   localparam logic [7:0] LF = 8'h0A;

   // Bits needed to hold values 0..n-1, never less than one.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ppm_sram_loader_timeout_counter.sv
// Idle-cycle watchdog: counts enabled cycles since the last reload and flags
// the LIMIT-th one. A reload in the expiring cycle suppresses the flag.
module timeout_counter #(
   parameter int unsigned WIDTH = 26,
   parameter int unsigned LIMIT = 50_000_000
) (
   input  logic Clock,
   input  logic Resetn,
   input  logic reload,
   input  logic enable,
   output logic expired
);

   localparam logic [WIDTH-1:0] LP_LAST = WIDTH'(LIMIT - 1);

   logic [WIDTH-1:0] r_cnt;

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn)
         r_cnt <= '0;
      else if (reload)
         r_cnt <= '0;
      else if (enable && (r_cnt != LP_LAST))
         r_cnt <= r_cnt + 1'b1;
   end

   assign expired = enable && !reload && (r_cnt == LP_LAST);

endmodule

// File: rtl/ppm_sram_loader.sv
// Streams a binary PPM from a byte source into 16-bit SRAM words: skips the
// text header, packs byte pairs, and ends the transfer after an idle timeout.
module ppm_sram_loader
   import ppm_sram_loader_pkg::*;
#(
   parameter int unsigned HEADER_LINES   = 3,
   parameter int unsigned ADDR_W         = 18,
   parameter int unsigned BASE_ADDR      = 0,
   parameter int unsigned MAX_WORDS      = 2**ADDR_W - BASE_ADDR,
   parameter int unsigned HI_FIRST       = 1,
   parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              Start,
   input  logic              Byte_valid,
   input  logic [7:0]        Byte_data,
   output logic [ADDR_W-1:0] SRAM_address,
   output logic [15:0]       SRAM_write_data,
   output logic              SRAM_we_n,
   output logic              Busy,
   output logic              Done,
   output logic [ADDR_W:0]   Word_count,
   output logic              Overflow
);

   localparam int unsigned       LINE_W   = cnt_w(HEADER_LINES + 1);
   localparam int unsigned       TMO_W    = cnt_w(TIMEOUT_CYCLES);
   localparam logic [ADDR_W:0]   LP_MAX   = (ADDR_W + 1)'(MAX_WORDS);
   localparam logic [ADDR_W-1:0] LP_BASE  = ADDR_W'(BASE_ADDR);
   localparam logic [LINE_W-1:0] LP_LINES = LINE_W'(HEADER_LINES);

   loader_state_t     r_state, w_next;
   logic [LINE_W-1:0] r_lines;
   logic              r_got_byte;
   logic              r_half_vld;
   logic [7:0]        r_half_byte;
   logic [ADDR_W-1:0] r_addr;
   logic [15:0]       r_wdata;
   logic              r_we_n;
   logic [ADDR_W:0]   r_count;
   logic              r_ovf;

   logic w_start_ok, w_full, w_last_lf, w_expired, w_tmo_en, w_tmo_reload;
   logic w_busy, w_done;

   assign w_start_ok   = (r_state == S_IDLE) && Start;
   assign w_full       = (r_count == LP_MAX);
   assign w_last_lf    = Byte_valid && (Byte_data == LF) && ((r_lines + 1'b1) == LP_LINES);
   assign w_tmo_en     = r_got_byte && ((r_state == S_HEADER) || (r_state == S_PAYLOAD));
   assign w_tmo_reload = Byte_valid || w_start_ok;

   timeout_counter #(
      .WIDTH (TMO_W),
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .Clock   (Clock),
      .Resetn  (Resetn),
      .reload  (w_tmo_reload),
      .enable  (w_tmo_en),
      .expired (w_expired)
   );

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   // w_expired is already masked by Byte_valid, so a late byte keeps the transfer alive.
   always_comb begin
      w_next = r_state;
      w_busy = 1'b0;
      w_done = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (Start)
               w_next = (HEADER_LINES == 0) ? S_PAYLOAD : S_HEADER;
         end
         S_HEADER: begin
            w_busy = 1'b1;
            if (w_last_lf)
               w_next = S_PAYLOAD;
            else if (w_expired)
               w_next = S_DONE;
         end
         S_PAYLOAD: begin
            w_busy = 1'b1;
            if (w_expired)
               w_next = r_half_vld ? S_FLUSH : S_DONE;
         end
         S_FLUSH: begin
            w_busy = 1'b1;
            w_next = S_DONE;
         end
         S_DONE: begin
            w_done = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         r_lines     <= '0;
         r_got_byte  <= 1'b0;
         r_half_vld  <= 1'b0;
         r_half_byte <= '0;
         r_addr      <= LP_BASE;
         r_wdata     <= '0;
         r_we_n      <= 1'b1;
         r_count     <= '0;
         r_ovf       <= 1'b0;
      end else begin
         r_we_n <= 1'b1;
         if (w_start_ok) begin
            r_lines    <= '0;
            r_got_byte <= 1'b0;
            r_half_vld <= 1'b0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
         end
         if ((r_state == S_HEADER) && Byte_valid) begin
            r_got_byte <= 1'b1;
            if (Byte_data == LF)
               r_lines <= r_lines + 1'b1;
         end
         // Once full, bytes are dropped outright so no half-word can reach the flush path.
         if ((r_state == S_PAYLOAD) && Byte_valid) begin
            r_got_byte <= 1'b1;
            if (w_full) begin
               r_ovf <= 1'b1;
            end else if (!r_half_vld) begin
               r_half_byte <= Byte_data;
               r_half_vld  <= 1'b1;
            end else begin
               r_half_vld <= 1'b0;
               r_we_n     <= 1'b0;
               r_addr     <= LP_BASE + r_count[ADDR_W-1:0];
               r_wdata    <= (HI_FIRST != 0) ? {r_half_byte, Byte_data}
                                             : {Byte_data, r_half_byte};
               r_count    <= r_count + 1'b1;
            end
         end
         // Flush write is issued on the way into S_FLUSH so the strobe is low during it.
         if ((r_state == S_PAYLOAD) && w_expired && r_half_vld) begin
            r_half_vld <= 1'b0;
            r_we_n     <= 1'b0;
            r_addr     <= LP_BASE + r_count[ADDR_W-1:0];
            r_wdata    <= (HI_FIRST != 0) ? {r_half_byte, 8'h00} : {8'h00, r_half_byte};
            r_count    <= r_count + 1'b1;
         end
      end
   end

   assign SRAM_address    = r_addr;
   assign SRAM_write_data = r_wdata;
   assign SRAM_we_n       = r_we_n;
   assign Busy            = w_busy;
   assign Done            = w_done;
   assign Word_count      = r_count;
   assign Overflow        = r_ovf;

endmodule

// File: tb/tb_ppm_sram_loader.sv
// Scoreboard bench: three loader instances (HI_FIRST=1, HI_FIRST=0, MAX_WORDS=2)
// share one byte stream; only the started instance reacts.
module tb_ppm_sram_loader;

   localparam int AW   = 8;
   localparam int BASE = 16;
   localparam int TMO  = 20;

   typedef struct packed {
      logic [1:0]    id;
      logic [AW-1:0] a;
      logic [15:0]   d;
   } wr_t;

   typedef struct packed {
      logic [1:0]  id;
      logic [AW:0] wc;
      logic        ovf;
   } done_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [2:0]    start;
   logic          bv;
   logic [7:0]    bd;
   logic [AW-1:0] addr [3];
   logic [15:0]   wd   [3];
   logic          we_n [3];
   logic          busy [3];
   logic          done [3];
   logic [AW:0]   wc   [3];
   logic          ovf  [3];

   wr_t   wq[$];
   done_t dq[$];
   int    n_pass = 0;
   int    n_tot  = 0;
   logic [7:0] hdr [11];

   always #5 clk = ~clk;

   ppm_sram_loader #(.ADDR_W(AW), .BASE_ADDR(BASE), .HI_FIRST(1), .TIMEOUT_CYCLES(TMO)) dut0 (
      .Clock(clk), .Resetn(rst_n), .Start(start[0]), .Byte_valid(bv), .Byte_data(bd),
      .SRAM_address(addr[0]), .SRAM_write_data(wd[0]), .SRAM_we_n(we_n[0]),
      .Busy(busy[0]), .Done(done[0]), .Word_count(wc[0]), .Overflow(ovf[0]));

   ppm_sram_loader #(.ADDR_W(AW), .BASE_ADDR(BASE), .HI_FIRST(0), .TIMEOUT_CYCLES(TMO)) dut1 (
      .Clock(clk), .Resetn(rst_n), .Start(start[1]), .Byte_valid(bv), .Byte_data(bd),
      .SRAM_address(addr[1]), .SRAM_write_data(wd[1]), .SRAM_we_n(we_n[1]),
      .Busy(busy[1]), .Done(done[1]), .Word_count(wc[1]), .Overflow(ovf[1]));

   ppm_sram_loader #(.ADDR_W(AW), .BASE_ADDR(BASE), .MAX_WORDS(2), .HI_FIRST(1),
                     .TIMEOUT_CYCLES(TMO)) dut2 (
      .Clock(clk), .Resetn(rst_n), .Start(start[2]), .Byte_valid(bv), .Byte_data(bd),
      .SRAM_address(addr[2]), .SRAM_write_data(wd[2]), .SRAM_we_n(we_n[2]),
      .Busy(busy[2]), .Done(done[2]), .Word_count(wc[2]), .Overflow(ovf[2]));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // Monitor: every write strobe and Done pulse must match the head of its queue.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         for (int k = 0; k < 3; k++) begin
            if (we_n[k] === 1'b0) begin
               if (wq.size() == 0) begin
                  n_tot++;
                  $display("FAIL unexpected_write: dut%0d addr %0h data %0h", k, addr[k], wd[k]);
               end else begin
                  wr_t e;
                  e = wq.pop_front();
                  chk("write_dut", k, 32'(e.id));
                  chk("write_addr", 32'(addr[k]), 32'(e.a));
                  chk("write_data", 32'(wd[k]), 32'(e.d));
               end
            end
            if (done[k] === 1'b1) begin
               if (dq.size() == 0) begin
                  n_tot++;
                  $display("FAIL unexpected_done: dut%0d", k);
               end else begin
                  done_t e;
                  e = dq.pop_front();
                  chk("done_dut", k, 32'(e.id));
                  chk("word_count", 32'(wc[k]), 32'(e.wc));
                  chk("overflow", 32'(ovf[k]), 32'(e.ovf));
                  chk("busy_at_done", 32'(busy[k]), 0);
               end
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      bv = 1'b1;
      bd = b;
      @(posedge clk);
      #1;
      bv = 1'b0;
   endtask

   task automatic start_dut(input int k);
      start[k] = 1'b1;
      @(posedge clk);
      #1;
      start = '0;
      chk("busy_after_start", 32'(busy[k]), 1);
   endtask

   task automatic send_header();
      for (int i = 0; i < 11; i++) send(hdr[i]);
   endtask

   task automatic exp_wr(input int k, input int a, input logic [15:0] d);
      wq.push_back('{id: 2'(k), a: AW'(a), d: d});
   endtask

   task automatic exp_done(input int k, input int n, input logic o);
      dq.push_back('{id: 2'(k), wc: (AW+1)'(n), ovf: o});
   endtask

   // Cycles from the last byte's sampling edge to the Done pulse.
   task automatic wait_done(input int k, input int exp);
      int  n;
      bit  seen;
      n    = 0;
      seen = 0;
      while (n < 200 && !seen) begin
         @(posedge clk);
         n++;
         #1;
         if (done[k] === 1'b1) seen = 1;
      end
      if (!seen) chk("done_timeout", 0, 1);
      else       chk("done_latency", n, exp);
      idle(1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $display("%0d/%0d checks passed", n_pass, n_tot + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      hdr = '{8'h50, 8'h36, 8'h0A, 8'h34, 8'h20, 8'h32, 8'h0A, 8'h32, 8'h35, 8'h35, 8'h0A};
      rst_n = 1'b0;
      start = '0;
      bv    = 1'b0;
      bd    = '0;
      idle(3);
      chk("rst_we_n", 32'(we_n[0]), 1);
      chk("rst_addr", 32'(addr[0]), BASE);
      chk("rst_wdata", 32'(wd[0]), 0);
      chk("rst_busy", 32'(busy[0]), 0);
      chk("rst_done", 32'(done[0]), 0);
      chk("rst_wc", 32'(wc[0]), 0);
      chk("rst_ovf", 32'(ovf[0]), 0);
      rst_n = 1'b1;
      idle(2);

      // Basic stream, high byte first
      exp_wr(0, BASE, 16'h1122);
      exp_wr(0, BASE + 1, 16'h3344);
      exp_done(0, 2, 1'b0);
      start_dut(0);
      send_header();
      send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      wait_done(0, TMO);

      // Same stream, low byte first
      exp_wr(1, BASE, 16'h2211);
      exp_wr(1, BASE + 1, 16'h4433);
      exp_done(1, 2, 1'b0);
      start_dut(1);
      send_header();
      send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      wait_done(1, TMO);

      // Odd byte count flushes a padded word; a mid-transfer Start is ignored
      exp_wr(0, BASE, 16'hAABB);
      exp_wr(0, BASE + 1, 16'hCC00);
      exp_done(0, 2, 1'b0);
      start_dut(0);
      send_header();
      send(8'hAA);
      start_dut(0);
      send(8'hBB); idle(2); send(8'hCC);
      wait_done(0, TMO + 1);

      // Capacity limit of two words
      exp_wr(2, BASE, 16'h0102);
      exp_wr(2, BASE + 1, 16'h0304);
      exp_done(2, 2, 1'b1);
      start_dut(2);
      send_header();
      for (int i = 1; i <= 6; i++) begin
         send(8'(i));
         idle(1);
      end
      wait_done(2, TMO - 1);

      // Back-to-back payload bytes
      for (int i = 0; i < 4; i++) exp_wr(0, BASE + i, {8'(8'h10 + 2*i), 8'(8'h11 + 2*i)});
      exp_done(0, 4, 1'b0);
      start_dut(0);
      send_header();
      for (int i = 0; i < 8; i++) send(8'(8'h10 + i));
      wait_done(0, TMO);

      // Byte landing in the expiry cycle keeps the transfer alive
      exp_wr(0, BASE, 16'hA1A2);
      exp_done(0, 1, 1'b0);
      start_dut(0);
      send_header();
      send(8'hA1);
      idle(TMO - 1);
      send(8'hA2);
      wait_done(0, TMO);

      // Reset mid-transfer with a pending half-word, then a fresh stream
      exp_wr(0, BASE, 16'h5566);
      start_dut(0);
      send_header();
      send(8'h55); send(8'h66); send(8'h77);
      idle(2);
      rst_n = 1'b0;
      idle(2);
      chk("midrst_wc", 32'(wc[0]), 0);
      chk("midrst_busy", 32'(busy[0]), 0);
      chk("midrst_we_n", 32'(we_n[0]), 1);
      chk("midrst_addr", 32'(addr[0]), BASE);
      rst_n = 1'b1;
      idle(TMO + 5);
      chk("post_rst_idle", 32'(busy[0]), 0);
      exp_wr(0, BASE, 16'h9988);
      exp_done(0, 1, 1'b0);
      start_dut(0);
      chk("restart_wc", 32'(wc[0]), 0);
      send_header();
      send(8'h99); send(8'h88);
      wait_done(0, TMO);

      idle(5);
      chk("write_queue_empty", wq.size(), 0);
      chk("done_queue_empty", dq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
